aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule. Takes the 128-bit cipher key, emits round keys 0..NR one at a time

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_sbox.sv | 45 ++++
 rtl/aes_key_expand.sv | 123 ++++++++++++
 tb/tb_aes_key_expand.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-schedule FSM encoding and round-constant lookup.
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_NR_128 = 10;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } kexp_state_e;

  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b; 8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26; 8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2; 8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed; 8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f; 8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec; 8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14; 8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d; 8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f; 8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11; 8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f; 8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
    endcase
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: key 0 one cycle after start, then one key per accepted beat; a stalled key is held.
// Optional KEXP_KEY_STORE_EN keeps every accepted round key readable by index for reverse-order replay.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] key_in,
  output logic                 busy,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [AES_BLK_W-1:0] round_key,
  output logic [3:0]           round_idx,
  output logic                 done
`ifdef KEXP_KEY_STORE_EN
  ,
  input  logic [3:0]           rd_idx,
  output logic [AES_BLK_W-1:0] rd_key
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  kexp_state_e          state_q, state_d;
  logic [AES_BLK_W-1:0] key_q, key_d;
  logic [3:0]           idx_q, idx_d;
  logic                 done_q, done_d;

  logic [AES_WORD_W-1:0] w0, w1, w2, w3, rot_w, sub_w, t_w;
  logic [AES_WORD_W-1:0] nw0, nw1, nw2, nw3;

  assign w0    = key_q[127:96];
  assign w1    = key_q[95:64];
  assign w2    = key_q[63:32];
  assign w3    = key_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte (rot_w[8*b +: 8]),
      .out_byte(sub_w[8*b +: 8])
    );
  end

  assign t_w = sub_w ^ {aes_rcon(idx_q + 4'd1), 24'h000000};
  assign nw0 = w0 ^ t_w;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  // A start landing in the done cycle is dropped so the consumer sees a clean idle gap.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = {nw0, nw1, nw2, nw3};
            idx_d = idx_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Valid and busy coincide: the key register is always presentable while emitting.
  assign busy      = (state_q == EMIT);
  assign key_valid = (state_q == EMIT);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

`ifdef KEXP_KEY_STORE_EN
  logic [AES_BLK_W-1:0] store_q [0:AES_NR_128];
  logic [AES_BLK_W-1:0] store_d [0:AES_NR_128];

  always_comb begin
    store_d = store_q;
    if (key_valid && key_ready) store_d[idx_q] = key_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= AES_NR_128; i++) store_q[i] <= '0;
    end else begin
      store_q <= store_d;
    end
  end

  assign rd_key = (rd_idx <= LAST_IDX) ? store_q[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomised scoreboard bench for aes_key_expand against a FIPS-197 style reference schedule.
module tb_aes_key_expand;

  localparam int NR = 10;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy, key_valid, key_ready, done;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
`ifdef KEXP_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  aes_key_expand #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .key_valid(key_valid), .key_ready(key_ready), .round_key(round_key),
    .round_idx(round_idx), .done(done)
`ifdef KEXP_KEY_STORE_EN
    , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  exp_t         sb_q[$];
  logic         expect_done = 1'b0;
  logic [127:0] got_key [0:NR];
  logic [7:0]   sb_tab [0:255];
  logic [127:0] mk [0:NR];

  // Reference S-box built from the GF(2^8) inverse and the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sb_tab[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  task automatic model_keys(input logic [127:0] key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k <= NR; k++) mk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented key against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && done) begin
        n_tests++; n_fail++;
        $display("FAIL valid_and_done: both high at idx %0d", round_idx);
      end
      if (expect_done) begin
        n_tests++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL done_pulse: got %b expected 1", done);
        end
        expect_done = 1'b0;
      end else if (done) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_done: got 1 expected 0");
      end
      if (key_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_key: idx %0d key %h with empty scoreboard", round_idx, round_key);
        end else begin
          n_tests++;
          if (round_key !== sb_q[0].key || round_idx !== sb_q[0].idx || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL key_out: got idx %0d key %h busy %b expected idx %0d key %h busy 1",
                     round_idx, round_key, busy, sb_q[0].idx, sb_q[0].key);
          end
          if (key_ready) begin
            got_key[sb_q[0].idx] = round_key;
            if (sb_q[0].idx == 4'(NR)) expect_done = 1'b1;
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  task automatic issue(input logic [127:0] key);
    model_keys(key);
    for (int k = 0; k <= NR; k++) sb_q.push_back('{idx: 4'(k), key: mk[k]});
    for (int k = 0; k <= NR; k++) got_key[k] = 'x;
    key_in = key;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_ready, input bit extra);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      key_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", {127'd0, done}, 128'd1);
    if (extra) cyc();
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n;
    n = 0;
    key_ready = 1'b1;
    while (!(key_valid === 1'b1 && round_idx === idx) && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) chk("idx_timeout", {124'd0, round_idx}, {124'd0, idx});
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
`ifdef KEXP_KEY_STORE_EN
    rd_idx = 4'd0;
`endif
    build_sbox();
    repeat (2) cyc();
    chk("rst_valid", {127'd0, key_valid}, 128'd0);
    chk("rst_busy",  {127'd0, busy},      128'd0);
    chk("rst_done",  {127'd0, done},      128'd0);
    chk("rst_key",   round_key,           128'd0);
    chk("rst_idx",   {124'd0, round_idx}, 128'd0);
    rst = 1'b0;
    cyc();

    // FIPS-197 vector, consumer always ready
    issue(FIPS_KEY);
    wait_done(1'b0, 1'b1);
    chk("fips_idx1",  got_key[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_idx10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_drain", 128'(sb_q.size()), 128'd0);
`ifdef KEXP_KEY_STORE_EN
    rd_idx = 4'd10; #1 chk("store_idx10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_idx = 4'd0;  #1 chk("store_idx0",  rd_key, FIPS_KEY);
    rd_idx = 4'd12; #1 chk("store_idx12", rd_key, 128'd0);
    rd_idx = 4'd0;
    cyc();
`endif

    // All-zero key
    issue(128'd0);
    wait_done(1'b0, 1'b1);
    chk("zero_idx1",  got_key[1],  128'h62636363626363636263636362636363);
    chk("zero_idx10", got_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // FIPS key under random backpressure, then random keys
    issue(FIPS_KEY);
    wait_done(1'b1, 1'b1);
    chk("bp_idx10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("bp_drain", 128'(sb_q.size()), 128'd0);
    repeat (4) begin
      issue({$urandom, $urandom, $urandom, $urandom});
      wait_done(1'b1, 1'b1);
      chk("rnd_drain", 128'(sb_q.size()), 128'd0);
    end

    // start while busy and in the done cycle is ignored; a cycle later it is taken
    issue({$urandom, $urandom, $urandom, $urandom});
    wait_idx(4'd4);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(1'b0, 1'b0);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_cycle_start_busy", {127'd0, busy}, 128'd0);
    issue({$urandom, $urandom, $urandom, $urandom});
    wait_done(1'b1, 1'b1);
    chk("restart_drain", 128'(sb_q.size()), 128'd0);

    // async reset between edges mid-schedule
    issue({$urandom, $urandom, $urandom, $urandom});
    wait_idx(4'd6);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {127'd0, key_valid}, 128'd0);
    chk("arst_busy",  {127'd0, busy},      128'd0);
    chk("arst_done",  {127'd0, done},      128'd0);
    chk("arst_key",   round_key,           128'd0);
    chk("arst_idx",   {124'd0, round_idx}, 128'd0);
    sb_q.delete();
    expect_done = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    issue(FIPS_KEY);
    wait_done(1'b1, 1'b1);
    chk("post_rst_idx0",  got_key[0],  FIPS_KEY);
    chk("post_rst_idx10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
